// File: rtl/z80_io_rd_port_pkg.sv
// Shared constants, state encoding and status-byte packing for the Z80 I/O read port.
package z80kaa_pkg;

  localparam logic [3:0] PORT_DATA_DEF = 4'h0;
  localparam logic [3:0] PORT_STAT_DEF = 4'h1;

  localparam int unsigned ST_NE      = 0;
  localparam int unsigned ST_FULL    = 1;
  localparam int unsigned ST_OVF     = 2;
  localparam int unsigned ST_CNT_LSB = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } rd_state_e;

  function automatic logic [7:0] status_byte(
    input logic [3:0] cnt,
    input logic       ovf,
    input logic       full,
    input logic       not_empty
  );
    logic [7:0] s;
    s                  = '0;
    s[ST_NE]           = not_empty;
    s[ST_FULL]         = full;
    s[ST_OVF]          = ovf;
    s[ST_CNT_LSB +: 4] = cnt;
    return s;
  endfunction

endpackage

// File: rtl/z80_io_rd_port_if.sv
// Z80 bus and producer-side signals of the I/O read port; master = CPU/producer, slave = port.
interface z80_io_rd_port_if;
  logic [3:0] adr;
  logic       iorq;
  logic       rd;
  logic       m1;
  logic [7:0] data_out;
  logic       data_oe;
  logic [7:0] in_byte;
  logic       in_valid;
  logic       in_ready;
  logic       int_n;

  modport master (
    output adr, iorq, rd, m1, in_byte, in_valid,
    input  data_out, data_oe, in_ready, int_n
  );

  modport slave (
    input  adr, iorq, rd, m1, in_byte, in_valid,
    output data_out, data_oe, in_ready, int_n
  );
endinterface

// File: rtl/z80_io_rd_port_fifo.sv
// Show-ahead synchronous byte FIFO; power-of-two depth so pointers wrap naturally.
module io_byte_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     in_clock,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  always_ff @(posedge in_clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge in_clock) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/z80_io_rd_port.sv
// Z80 IN-cycle responder: data port pops a byte FIFO, status port reports fill/overflow.
// Optional macro Z80_IO_RD_IRQ_EN: int_n follows FIFO emptiness; otherwise int_n is tied high.
module z80_io_rd_port
  import z80kaa_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter logic [3:0]  PORT_DATA = PORT_DATA_DEF,
  parameter logic [3:0]  PORT_STAT = PORT_STAT_DEF,
  parameter logic [7:0]  EMPTY_VAL = 8'hFF
) (
  input logic               in_clock,
  input logic               rst,
  z80_io_rd_port_if.slave   bus
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic r_iorq_s1, r_iorq_s2;
  logic r_rd_s1,   r_rd_s2;
  logic r_m1_s1,   r_m1_s2;

  rd_state_e r_state;
  logic [7:0] r_data_out;
  logic       r_data_oe;
  logic       r_pop_pend;
  logic       r_sel_stat;
  logic       r_ovf;
  logic       r_int_n;

  logic          w_rd_cyc;
  logic          w_adr_data;
  logic          w_adr_stat;
  logic          w_push;
  logic          w_pop;
  logic          w_end;
  logic          w_ovf_clr;
  logic [7:0]    w_head;
  logic          w_empty;
  logic          w_full;
  logic [CW-1:0] w_count;
  logic [7:0]    w_cnt8;
  logic [7:0]    w_stat;

  // Strobes idle high, so the synchronisers reset to the inactive level.
  always_ff @(posedge in_clock) begin
    if (!rst) begin
      r_iorq_s1 <= 1'b1; r_iorq_s2 <= 1'b1;
      r_rd_s1   <= 1'b1; r_rd_s2   <= 1'b1;
      r_m1_s1   <= 1'b1; r_m1_s2   <= 1'b1;
    end else begin
      r_iorq_s1 <= bus.iorq; r_iorq_s2 <= r_iorq_s1;
      r_rd_s1   <= bus.rd;   r_rd_s2   <= r_rd_s1;
      r_m1_s1   <= bus.m1;   r_m1_s2   <= r_m1_s1;
    end
  end

  assign w_rd_cyc   = ~r_iorq_s2 & ~r_rd_s2 & r_m1_s2;
  assign w_adr_data = (bus.adr == PORT_DATA);
  assign w_adr_stat = (bus.adr == PORT_STAT);
  assign w_push     = bus.in_valid & ~w_full;
  assign w_end      = (r_state == DRIVE) & ~w_rd_cyc;
  assign w_pop      = w_end & r_pop_pend;
  assign w_ovf_clr  = w_end & r_sel_stat;
  assign w_cnt8     = 8'(w_count);
  assign w_stat     = status_byte(w_cnt8[3:0], r_ovf, w_full, ~w_empty);

  io_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .in_clock (in_clock),
    .rst      (rst),
    .push     (w_push),
    .pop      (w_pop),
    .din      (bus.in_byte),
    .dout     (w_head),
    .empty    (w_empty),
    .full     (w_full),
    .count    (w_count)
  );

  // Pop eligibility is decided when the byte is latched, so an empty read never pops
  // even if a push lands while the Z80 is still reading.
  always_ff @(posedge in_clock) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_data_out <= '0;
      r_data_oe  <= 1'b0;
      r_pop_pend <= 1'b0;
      r_sel_stat <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rd_cyc && (w_adr_data || w_adr_stat)) begin
            r_state    <= DRIVE;
            r_data_oe  <= 1'b1;
            r_pop_pend <= w_adr_data & ~w_empty;
            r_sel_stat <= ~w_adr_data;
            if (w_adr_data) r_data_out <= w_empty ? EMPTY_VAL : w_head;
            else            r_data_out <= w_stat;
          end
        end
        DRIVE: begin
          if (!w_rd_cyc) begin
            r_state    <= IDLE;
            r_data_oe  <= 1'b0;
            r_pop_pend <= 1'b0;
            r_sel_stat <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A new overflow wins over the end-of-status-read clear.
  always_ff @(posedge in_clock) begin
    if (!rst)                            r_ovf <= 1'b0;
    else if (bus.in_valid && w_full)     r_ovf <= 1'b1;
    else if (w_ovf_clr)                  r_ovf <= 1'b0;
  end

`ifdef Z80_IO_RD_IRQ_EN
  always_ff @(posedge in_clock) begin
    if (!rst) r_int_n <= 1'b1;
    else      r_int_n <= w_empty;
  end
`else
  assign r_int_n = 1'b1;
`endif

  assign bus.data_out = r_data_out;
  assign bus.data_oe  = r_data_oe;
  assign bus.in_ready = ~w_full;
  assign bus.int_n    = r_int_n;
endmodule

// File: doc/z80_io_rd_port.md
Name: z80_io_rd_port

Overview:
- Read-side counterpart of the CPLD's Z80 I/O write latch: answers Z80 IN cycles (IORQ+RD low, M1 high) on the low address nibble.
- Drives the data bus from a small byte FIFO filled by a CPLD-side producer, plus a status register.
- Runs entirely in the in_clock domain (8x cpu_clock); Z80 strobes are synchronised internally.
- Top level ties data_out/data_oe onto the inout data bus.

Parameters:
- DEPTH, 4: FIFO depth in bytes, power of two, 2..16.
- PORT_DATA, 4'h0: adr[3:0] value for the data read (pops FIFO).
- PORT_STAT, 4'h1: adr[3:0] value for the status read.
- EMPTY_VAL, 8'hFF: byte returned when the data port is read while the FIFO is empty.

Ports:
- in_clock  input  1  master clock; all logic on posedge.
- rst  input  1  synchronous reset, active-low.
- adr  input  4  Z80 A3..A0.
- iorq  input  1  Z80 /IORQ, active-low, asynchronous to in_clock.
- rd  input  1  Z80 /RD, active-low.
- m1  input  1  Z80 /M1, active-low.
- data_out  output  8  byte presented to the Z80 bus.
- data_oe  output  1  bus drive enable, 1 = drive.
- in_byte  input  8  producer data.
- in_valid  input  1  producer push request.
- in_ready  output  1  FIFO can accept; equals !full.
- int_n  output  1  interrupt request, active-low (see Optional Feature).

Behaviour:
- Reset (rst=0 at posedge):
  - FIFO emptied; overflow flag cleared; state IDLE.
  - data_oe=0, data_out=8'h00, in_ready=1, int_n=1.
- Reset mid-cycle: data_oe falls at the same edge. The aborted read never pops.
- Synchronisers: iorq, rd, m1 each pass through 2 flip-flops.
  - rd_cyc = !iorq_s & !rd_s & m1_s.
  - Interrupt acknowledge (m1 low) is never answered.
- adr is not synchronised. It is sampled on the IDLE->DRIVE edge, which is valid because the address is stable well before the strobes.
- States:
  - IDLE: if rd_cyc and adr matches PORT_DATA or PORT_STAT, latch the byte into data_out, set data_oe=1, go to DRIVE. Unmatched addresses stay in IDLE with data_oe=0.
  - DRIVE: hold data_out and data_oe. When rd_cyc drops, set data_oe=0 and perform the end-of-read action, then go to IDLE.
- Latency: strobe assertion to data_oe=1 is 3 in_clock edges. Deassertion to data_oe=0 is 3 edges.
- Data port:
  - data_out = FIFO head, or EMPTY_VAL when empty.
  - At end of read, pop only if the FIFO was non-empty when the byte was latched.
- Status port: data_out = {count[3:0], 1'b0, ovf, full, !empty}, with count zero-extended.
  - At end of read, clear ovf.
  - If an overflow occurs in the same edge as the clear, ovf stays 1.
- Push: when in_valid & in_ready, write in_byte at the tail.
  - in_valid while full: byte dropped, ovf set (sticky), no state change otherwise.
- Simultaneous push and pop in one edge:
  - Both take effect; count unchanged.
  - When full with a pop in that edge, the push is still rejected because in_ready was 0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits, range 0..DEPTH.
- The FIFO head seen during DRIVE may change only through a push to an empty FIFO. data_out is latched, so the driven byte never glitches.

Optional Feature:
- Macro: Z80_IO_RD_IRQ_EN.
- Defined: int_n is registered and equals !(FIFO non-empty), updated every edge.
  - It stays asserted through the acknowledge cycle.
  - It releases one edge after the pop that empties the FIFO.
- Not defined: int_n is constant 1. The port is kept so the top level is unchanged.

Decomposition:
- Shared package z80kaa_pkg:
  - Port address constants.
  - Status bit index constants: ST_NE=0, ST_FULL=1, ST_OVF=2, ST_CNT_LSB=4.
  - State enum: IDLE, DRIVE.
- Sub-module io_byte_fifo: synchronous FIFO.
  - Parameter DEPTH.
  - Ports: push, pop, din, dout (head, show-ahead), empty, full, count.
  - Clocked by in_clock, reset by rst.

Test Plan:
- Reset: hold rst=0 for 2 edges with the strobes low -> data_oe=0, int_n=1, in_ready=1; a status read then returns 8'h00.
- Push 8'hA5 and 8'h3C, then IN from port 0 twice -> first read drives 8'hA5, second drives 8'h3C; data_oe rises 3 edges after the strobe; final status read returns 8'h00.
- Read port 0 while empty -> 8'hFF driven, no pop, count stays 0.
- Push 5 bytes with DEPTH=4 -> in_ready=0 after 4; status = 8'h47; next status read = 8'h43 (ovf cleared).
- IORQ+RD low with m1 low, and a read of adr=4'h7 -> data_oe stays 0 throughout, FIFO unchanged.
- Push on the same edge as the end-of-read pop with count=2 -> count stays 2; with Z80_IO_RD_IRQ_EN defined, int_n=0 until the last byte is read, then 1.
